// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped IO decode, UART handshake stall FSM and read-mux select.
// Optional cycle/instruction counters built when IO_PERF_COUNTERS_EN is defined.
module io_ctrl (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        InstrValid,
    input  logic        DataInReady,
    input  logic        DataOutValid,
    output logic        Stall,
    output logic        WEDM,
    output logic        WEIM,
    output logic        WEUART,
    output logic        REUART,
    output logic [1:0]  UARTsel,
    output logic [1:0]  RDsel,
    output logic [31:0] IO_Rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        RX_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] OFF_RX_STAT = 8'h00;
    localparam logic [7:0] OFF_RX_DATA = 8'h04;
    localparam logic [7:0] OFF_TX_STAT = 8'h08;
    localparam logic [7:0] OFF_TX_DATA = 8'h0C;
    localparam logic [7:0] OFF_CYC     = 8'h10;
    localparam logic [7:0] OFF_INS     = 8'h14;
    localparam logic [7:0] OFF_CLR     = 8'h18;

    state_t     state_q;
    state_t     state_d;
    logic       io_hit;
    logic       dmem_hit;
    logic       imem_hit;
    logic [7:0] off;
    logic       tx_req;
    logic       rx_req;
    logic       uart_off;

    always_comb begin
        io_hit   = Address[31];
        dmem_hit = ~Address[31] & Address[28];
        imem_hit = ~Address[31] & Address[29];
        off      = Address[7:0];
        tx_req   = io_hit & MemWrite & (off == OFF_TX_DATA);
        rx_req   = io_hit & MemRead & (off == OFF_RX_DATA);
        uart_off = (off == OFF_RX_STAT) | (off == OFF_RX_DATA)
                 | (off == OFF_TX_STAT) | (off == OFF_TX_DATA);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // While waiting, the pipeline is frozen, so the held access is implied by state.
    always_comb begin
        state_d = state_q;
        Stall   = 1'b0;
        WEUART  = 1'b0;
        REUART  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_req) begin
                    if (DataInReady) begin
                        WEUART = 1'b1;
                    end else begin
                        Stall   = 1'b1;
                        state_d = TX_WAIT;
                    end
                end else if (rx_req) begin
                    if (DataOutValid) begin
                        REUART = 1'b1;
                    end else begin
                        Stall   = 1'b1;
                        state_d = RX_WAIT;
                    end
                end
            end
            TX_WAIT: begin
                if (DataInReady) begin
                    WEUART  = 1'b1;
                    state_d = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            RX_WAIT: begin
                if (DataOutValid) begin
                    REUART  = 1'b1;
                    state_d = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d = IDLE;
            Stall   = 1'b0;
            WEUART  = 1'b0;
            REUART  = 1'b0;
        end
    end

    always_comb begin
        WEDM = MemWrite & dmem_hit & ~Stall & ~reset;
        WEIM = MemWrite & imem_hit & ~Stall & ~reset;
    end

    always_comb begin
        RDsel = 2'b01;
        if (MemRead) begin
            if (io_hit) begin
                RDsel = uart_off ? 2'b00 : 2'b11;
            end else begin
                RDsel = 2'b10;
            end
        end
        UARTsel = 2'b00;
        if (io_hit) begin
            if (off == OFF_RX_STAT) begin
                UARTsel = 2'b10;
            end else if (off == OFF_TX_STAT) begin
                UARTsel = 2'b01;
            end
        end
    end

`ifdef IO_PERF_COUNTERS_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_d;
    logic [31:0] ins_q;
    logic [31:0] ins_d;
    logic        clr;

    // Clear wins over the increment of the same cycle.
    always_comb begin
        clr   = io_hit & MemWrite & (off == OFF_CLR) & ~Stall;
        cyc_d = cyc_q + 32'd1;
        ins_d = ins_q + {31'd0, InstrValid & ~Stall};
        if (clr) begin
            cyc_d = '0;
            ins_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    always_comb begin
        IO_Rdata = '0;
        if (io_hit && off == OFF_CYC) begin
            IO_Rdata = cyc_q;
        end else if (io_hit && off == OFF_INS) begin
            IO_Rdata = ins_q;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{Address[30], Address[27:8]};
`else
    assign IO_Rdata = '0;

    logic unused_bits;
    assign unused_bits = ^{Address[30], Address[27:8], InstrValid,
                           OFF_CYC, OFF_INS, OFF_CLR};
`endif

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 io_ctrl SHALL expose the following ports, clock and reset first:
- CLK  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Address  in  32  execute-stage ALU result (effective address)
- MemRead  in  1  execute-stage instruction is a load
- MemWrite  in  1  execute-stage instruction is a store
- InstrValid  in  1  execute-stage instruction is non-bubble
- DataInReady  in  1  UART TX can accept a byte
- DataOutValid  in  1  UART RX holds a byte
- Stall  out  1  freeze PC and pipeline registers
- WEDM  out  1  data-memory write enable
- WEIM  out  1  instruction-memory write enable
- WEUART  out  1  one-cycle TX byte strobe (DataInValid)
- REUART  out  1  one-cycle RX byte consume strobe (DataOutReady)
- UARTsel  out  2  01 TX-ready status, 10 RX-valid status, 00 RX byte
- RDsel  out  2  00 UART, 01 ALU, 10 DMEM, 11 IO_Rdata
- IO_Rdata  out  32  counter readback value

Function
REQ-002 Decode SHALL be combinational on Address: Address[31]=1 is IO, else Address[28]=1 is DMEM and Address[29]=1 is IMEM; DMEM and IMEM may both be hit.
REQ-003 IO offsets (Address[7:0]) SHALL be: 0x00 RX-valid status, 0x04 RX byte, 0x08 TX-ready status, 0x0C TX byte, 0x10 cycle counter, 0x14 instruction counter, 0x18 counter clear (store only).
REQ-004 WEDM SHALL equal MemWrite & DMEM hit & ~Stall; WEIM SHALL equal MemWrite & IMEM hit & ~Stall.
REQ-005 RDsel SHALL be 01 for non-loads, 10 for DMEM loads, 00 for IO offsets 0x00–0x0C, 11 for 0x10/0x14; UARTsel SHALL be 10 at 0x00, 00 at 0x04, 01 at 0x08, 00 otherwise.
REQ-006 FSM states: IDLE, TX_WAIT, RX_WAIT.
REQ-007 IDLE, store to 0x0C: if DataInReady=1, WEUART=1 that cycle, stay IDLE; else Stall=1 combinationally, go TX_WAIT.
REQ-008 IDLE, load from 0x04: if DataOutValid=1, REUART=1 that cycle, stay IDLE; else Stall=1, go RX_WAIT.
REQ-009 TX_WAIT: Stall=1 while DataInReady=0; in the first cycle DataInReady=1, WEUART=1, Stall=0, go IDLE.
REQ-010 RX_WAIT: Stall=1 while DataOutValid=0; in the first cycle DataOutValid=1, REUART=1, Stall=0, go IDLE.
REQ-011 WEUART and REUART SHALL never assert while Stall=1 and never both in one cycle.
REQ-012 Status-register loads (0x00, 0x08) SHALL never stall.
REQ-013 Stores to read-only IO offsets and loads from 0x18 SHALL have no side effect and not stall; load from 0x18 returns IO_Rdata=0.

Reset
REQ-014 reset SHALL force state IDLE, Stall=0, WEUART=0, REUART=0, counters 0, in the same edge.
REQ-015 While reset=1, WEDM, WEIM, WEUART, REUART SHALL be 0 regardless of inputs.
REQ-016 reset asserted in TX_WAIT or RX_WAIT SHALL abandon the access without emitting a strobe.

Configuration
REQ-017 Macro IO_PERF_COUNTERS_EN defined: 32-bit cycle counter increments every non-reset cycle; instruction counter increments when InstrValid=1 and Stall=0; both wrap 0xFFFFFFFF→0; IO_Rdata returns cycle count at 0x10, instruction count at 0x14; store to 0x18 (when not stalled) clears both, clear overriding increment in the same cycle.
REQ-018 Macro IO_PERF_COUNTERS_EN undefined: no counter registers; IO_Rdata SHALL be constant 0; 0x18 store is a no-op; all other behaviour identical.

Verification
REQ-019 Store to 0x8000000C, DataInReady=1 -> WEUART=1 one cycle, Stall=0, WEDM=0.
REQ-020 Load 0x80000004, DataOutValid=0 for 5 cycles then 1 -> Stall=1 exactly 5 cycles, REUART=1 on 6th, Stall=0 then, RDsel=00, UARTsel=00.
REQ-021 Store to 0x10000010 with TX stalled (Stall=1) -> WEDM=0; same store unstalled -> WEDM=1; Address 0x30000000 store -> WEDM=1, WEIM=1.
REQ-022 reset pulsed during TX_WAIT -> next cycle state IDLE, Stall=0, WEUART never asserted.
REQ-023 (EN) 100 cycles after reset, 40 of them valid unstalled -> load 0x80000010 gives 100 (±read cycle), 0x80000014 gives 40; store 0x80000018 -> both read 0/1 next cycle.
REQ-024 (EN) cycle counter preset to 0xFFFFFFFF via force -> next cycle reads 0x00000000.
